pc_fetch_seq: RTL and testbench
===============================

// Module: pc_fetch_seq
// PURPOSE
//  Program-counter sequencer and instruction-fetch requester for the 19-bit CPU.
//  Holds the PC and issues fetch addresses to instruction memory over a
//  valid/ready handshake. Accepts branch, call and return redirects from execute
//  and keeps a return-address stack (RAS). The incrementer is a pc_addr instance
//  (b = 1); this block is its consumer side.
// PARAMETERS
//  ADDR_W     19  PC / address width
//  RESET_PC   0   PC loaded on reset
//  RAS_DEPTH  8   return-stack entries, power of two
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  fetch_valid   out  1       fetch_addr is a valid request
//  fetch_addr    out  ADDR_W  instruction address
//  fetch_ready   in   1       imem accepts the request this cycle
//  redir_valid   in   1       one-cycle redirect strobe from execute
//  redir_kind    in   2       00 JUMP, 01 CALL, 10 RET, 11 reserved (treated as JUMP)
//  redir_target  in   ADDR_W  target for JUMP/CALL; ignored for RET
//  redir_pc      in   ADDR_W  address of the redirecting instruction (CALL link)
//  halt          in   1       level; stop issuing fetches
//  ras_empty     out  1       stack count == 0
//  ras_full      out  1       stack count == RAS_DEPTH
//  ras_ovf       out  1       1-cycle pulse: CALL pushed while full
//  ras_unf       out  1       sticky until rst: RET popped while empty
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=BOOT, fetch_valid=0, RAS count=0, ras_empty=1,
//   ras_full=0, ras_ovf=0, ras_unf=0. rst mid-operation discards any pending
//   request and clears the stack.
//  States:
//   BOOT   fetch_valid=0; next state FETCH. Reset-to-first-request is 1 cycle.
//   FETCH  fetch_valid=1, fetch_addr=pc.
//          On accept (valid & ready): pc <= pc+1 (mod 2^ADDR_W; 0x7FFFF -> 0x00000).
//          Back-to-back accepts give one address per cycle.
//   FLUSH  fetch_valid=0 for exactly 1 cycle; pc already holds the target; next FETCH.
//   HALTED fetch_valid=0; pc is held; on !halt go to FETCH with the same pc.
//  Stability: while fetch_valid & !fetch_ready, fetch_addr is held. A redirect
//   never changes the address under a live request; it drops valid via FLUSH.
//  Redirect (any state except BOOT, takes effect the same edge):
//   - pc <= target; state <= FLUSH. Redirect latency to the new request is 2 cycles.
//   - If the request is accepted in the redirect cycle, the accept is honoured by
//     imem, but the pc+1 update is discarded.
//   - JUMP: target = redir_target.
//   - CALL: push redir_pc+1 (mod 2^ADDR_W), target = redir_target.
//   - RET:  pop; target = top of stack.
//  RAS is circular:
//   - CALL when full overwrites the oldest entry; count stays RAS_DEPTH; ras_ovf pulses.
//   - RET when empty: target = RESET_PC, ras_unf set, state <= HALTED (not FLUSH)
//     regardless of halt; leaves HALTED when halt=0.
//  Priority in one cycle: rst > redirect > halt > advance.
//  halt in FETCH:
//   - No live request, or accepted this cycle: go HALTED; the accept still advances pc.
//   - If valid & !ready: stay in FETCH until accepted, then HALTED.
//  Redirect while HALTED updates pc/RAS and stays HALTED if halt=1.
//  Outputs are registered; no combinational path from inputs to fetch_valid/addr.
// STRUCTURE
//  Package pc_fetch_pkg: ADDR_W, kind codes (KIND_JUMP/CALL/RET), state enum
//   (BOOT/FETCH/FLUSH/HALTED).
//  Sub-module pc_ras: circular RAS (push/pop/top, count, full/empty, ovf).
//  pc_addr instances provide pc+1 and redir_pc+1.
// TESTING
//  1 rst, then ready=1 for 4 cycles -> valid from cycle 2, addrs 0,1,2,3.
//  2 pc=0x00010, ready=0 for 3 cycles -> addr held at 0x00010, valid stays 1;
//    ready=1 -> next addr 0x00011.
//  3 CALL redir_pc=0x00020, target=0x01000; later RET -> 1 FLUSH cycle, fetch 0x01000..;
//    after RET fetch 0x00021, ras_empty=1.
//  4 pc=0x7FFFF accepted -> next fetch_addr 0x00000.
//  5 9 CALLs (depth 8) -> ras_ovf pulse on the 9th; 8 RETs return the last 8 links
//    newest-first; a 9th RET sets ras_unf and goes HALTED.
//  6 halt with valid & !ready -> request held until ready, then fetch_valid=0;
//    redirect + halt in the same cycle -> pc=target, HALTED; halt=0 -> fetch target.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC sequencer / fetch requester.
// Redirect kind codes and the fetch FSM state encoding.
package pc_fetch_pkg;

  localparam int ADDR_W = 19;

  localparam logic [1:0] KIND_JUMP = 2'b00;
  localparam logic [1:0] KIND_CALL = 2'b01;
  localparam logic [1:0] KIND_RET  = 2'b10;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH,
    HALTED
  } state_t;

endpackage

// File: rtl/pc_addr.sv
// Modular address adder: y = a + b, wrapping at 2^W.
// Used as the PC incrementer and the call-link generator.
module pc_addr #(
  parameter int W = 19
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the
// oldest entry and raises a one-cycle overflow pulse.
module pc_ras #(
  parameter int W     = 19,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_prev;
  logic [PW:0]   count;

  assign sp_prev = sp - PW'(1);
  assign top     = mem[sp_prev];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= push && full;
      if (push) begin
        sp <= sp + PW'(1);
        if (!full) count <= count + (PW+1)'(1);
      end else if (pop && !empty) begin
        sp    <= sp_prev;
        count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// PC sequencer and instruction-fetch requester with redirects
// (jump/call/return) and a circular return-address stack.
module pc_fetch_seq
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W_P  = ADDR_W,
  parameter logic [ADDR_W_P-1:0] RESET_PC = '0,
  parameter int                RAS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                fetch_valid,
  output logic [ADDR_W_P-1:0] fetch_addr,
  input  logic                fetch_ready,
  input  logic                redir_valid,
  input  logic [1:0]          redir_kind,
  input  logic [ADDR_W_P-1:0] redir_target,
  input  logic [ADDR_W_P-1:0] redir_pc,
  input  logic                halt,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                ras_unf
);

  state_t state, state_nxt;

  logic [ADDR_W_P-1:0] pc, pc_nxt;
  logic [ADDR_W_P-1:0] pc_inc, link, ras_top;
  logic                unf, unf_nxt;
  logic                push, pop;
  logic                redir, accept;
  logic                is_call, is_ret;

  pc_addr #(.W(ADDR_W_P)) u_inc (
    .a (pc),
    .b (ADDR_W_P'(1)),
    .y (pc_inc)
  );

  pc_addr #(.W(ADDR_W_P)) u_link (
    .a (redir_pc),
    .b (ADDR_W_P'(1)),
    .y (link)
  );

  pc_ras #(.W(ADDR_W_P), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (link),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf)
  );

  assign fetch_valid = (state == FETCH);
  assign fetch_addr  = pc;
  assign ras_unf     = unf;

  assign redir   = redir_valid && (state != BOOT);
  assign accept  = fetch_valid && fetch_ready;
  assign is_call = (redir_kind == KIND_CALL);
  assign is_ret  = (redir_kind == KIND_RET);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    unf_nxt   = unf;
    push      = 1'b0;
    pop       = 1'b0;
    if (redir) begin
      pc_nxt    = redir_target;
      state_nxt = halt ? HALTED : FLUSH;
      unique case (1'b1)
        is_call: push = 1'b1;
        is_ret: begin
          if (ras_empty) begin
            pc_nxt    = RESET_PC;
            unf_nxt   = 1'b1;
            state_nxt = HALTED;
          end else begin
            pop    = 1'b1;
            pc_nxt = ras_top;
          end
        end
        default: ;
      endcase
    end else begin
      unique case (state)
        BOOT:  state_nxt = FETCH;
        FETCH: begin
          if (accept) pc_nxt = pc_inc;
          // A stalled request must complete before halting.
          if (halt && accept) state_nxt = HALTED;
        end
        FLUSH:  state_nxt = halt ? HALTED : FETCH;
        HALTED: if (!halt) state_nxt = FETCH;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      unf   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      unf   <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: vector table for the basic
// fetch/redirect flow, hand sequences for RAS and halt corners.
module tb_pc_fetch_seq;
  import pc_fetch_pkg::*;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [1:0]  kind;
    logic [18:0] tgt;
    logic [18:0] rpc;
    logic        hlt;
    logic        ev;
    logic [18:0] ea;
    logic        ee;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [18:0] fetch_addr;
  logic        fetch_ready;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [18:0] redir_target;
  logic [18:0] redir_pc;
  logic        halt;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int checks = 0;
  int errors = 0;

  vec_t tbl [21];

  pc_fetch_seq dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_addr   (fetch_addr),
    .fetch_ready  (fetch_ready),
    .redir_valid  (redir_valid),
    .redir_kind   (redir_kind),
    .redir_target (redir_target),
    .redir_pc     (redir_pc),
    .halt         (halt),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rdy, input logic rv, input logic [1:0] kind,
    input logic [18:0] tgt, input logic [18:0] rpc,
    input logic hlt, input logic ev, input logic [18:0] ea,
    input logic ee
  );
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.kind = kind; v.tgt = tgt;
    v.rpc = rpc; v.hlt = hlt; v.ev = ev; v.ea = ea; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rdy, input logic rv,
                     input logic [1:0] kind, input logic [18:0] tgt,
                     input logic [18:0] rpc, input logic hlt);
    fetch_ready  = rdy;
    redir_valid  = rv;
    redir_kind   = kind;
    redir_target = tgt;
    redir_pc     = rpc;
    halt         = hlt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00000, 1);
    tbl[1]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00001, 1);
    tbl[2]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00002, 1);
    tbl[3]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00003, 1);
    tbl[4]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00004, 1);
    tbl[5]  = mk(1, 1, KIND_CALL, 19'h01000, 19'h00020, 0, 0, 19'h01000, 0);
    tbl[6]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h01000, 0);
    tbl[7]  = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h01001, 0);
    tbl[8]  = mk(0, 0, KIND_JUMP, 0, 0, 0, 1, 19'h01001, 0);
    tbl[9]  = mk(0, 1, KIND_RET,  19'h05555, 0, 0, 0, 19'h00021, 1);
    tbl[10] = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00021, 1);
    tbl[11] = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00022, 1);
    tbl[12] = mk(1, 1, 2'b11,     19'h00010, 0, 0, 0, 19'h00010, 1);
    tbl[13] = mk(0, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00010, 1);
    tbl[14] = mk(0, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00010, 1);
    tbl[15] = mk(0, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00010, 1);
    tbl[16] = mk(0, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00010, 1);
    tbl[17] = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00011, 1);
    tbl[18] = mk(0, 1, KIND_JUMP, 19'h7FFFF, 0, 0, 0, 19'h7FFFF, 1);
    tbl[19] = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h7FFFF, 1);
    tbl[20] = mk(1, 0, KIND_JUMP, 0, 0, 0, 1, 19'h00000, 1);

    rst = 1'b1;
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    step();
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_addr",  32'(fetch_addr), 0);
    chk("rst_empty", 32'(ras_empty), 1);
    chk("rst_full",  32'(ras_full), 0);
    chk("rst_ovf",   32'(ras_ovf), 0);
    chk("rst_unf",   32'(ras_unf), 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drv(tbl[i].rdy, tbl[i].rv, tbl[i].kind, tbl[i].tgt,
          tbl[i].rpc, tbl[i].hlt);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i),  32'(fetch_addr),  32'(tbl[i].ea));
      chk($sformatf("vec%0d_empty", i), 32'(ras_empty),   32'(tbl[i].ee));
    end

    // Nine calls into an eight-deep stack.
    for (int i = 0; i < 9; i++) begin
      drv(0, 1, KIND_CALL, 19'h02000 + 19'(i), 19'h00100 + 19'(i), 0);
      step();
      chk($sformatf("call%0d_addr", i), 32'(fetch_addr), 32'h2000 + i);
      chk($sformatf("call%0d_ovf", i),  32'(ras_ovf),   32'(i == 8));
      chk($sformatf("call%0d_full", i), 32'(ras_full),  32'(i >= 7));
    end
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    chk("ovf_pulse_end", 32'(ras_ovf), 0);
    chk("call_idle_valid", 32'(fetch_valid), 1);
    for (int j = 0; j < 8; j++) begin
      drv(0, 1, KIND_RET, 0, 0, 0);
      step();
      chk($sformatf("ret%0d_addr", j),  32'(fetch_addr), 32'h109 - j);
      chk($sformatf("ret%0d_empty", j), 32'(ras_empty),  32'(j == 7));
      chk($sformatf("ret%0d_unf", j),   32'(ras_unf),    0);
    end
    drv(0, 1, KIND_RET, 19'h01234, 0, 0);
    step();
    chk("unf_addr",  32'(fetch_addr), 0);
    chk("unf_set",   32'(ras_unf), 1);
    chk("unf_valid", 32'(fetch_valid), 0);
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    chk("unf_resume_valid", 32'(fetch_valid), 1);
    chk("unf_resume_addr",  32'(fetch_addr), 0);
    chk("unf_sticky",       32'(ras_unf), 1);

    // Halt against a stalled request, then redirect while halting.
    drv(0, 1, KIND_JUMP, 19'h00300, 0, 0);
    step();
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    chk("h_pre_valid", 32'(fetch_valid), 1);
    chk("h_pre_addr",  32'(fetch_addr), 32'h300);
    drv(0, 0, KIND_JUMP, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("h_stall%0d_valid", k), 32'(fetch_valid), 1);
      chk($sformatf("h_stall%0d_addr", k),  32'(fetch_addr), 32'h300);
    end
    drv(1, 0, KIND_JUMP, 0, 0, 1);
    step();
    chk("h_acc_valid", 32'(fetch_valid), 0);
    chk("h_acc_addr",  32'(fetch_addr), 32'h301);
    step();
    chk("h_hold_valid", 32'(fetch_valid), 0);
    chk("h_hold_addr",  32'(fetch_addr), 32'h301);
    drv(0, 1, KIND_JUMP, 19'h00400, 0, 1);
    step();
    chk("h_redir_valid", 32'(fetch_valid), 0);
    chk("h_redir_addr",  32'(fetch_addr), 32'h400);
    drv(0, 0, KIND_JUMP, 0, 0, 1);
    step();
    chk("h_redir_stay", 32'(fetch_valid), 0);
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    chk("h_rel_valid", 32'(fetch_valid), 1);
    chk("h_rel_addr",  32'(fetch_addr), 32'h400);
    drv(0, 1, KIND_JUMP, 19'h00500, 0, 1);
    step();
    chk("rh_valid", 32'(fetch_valid), 0);
    chk("rh_addr",  32'(fetch_addr), 32'h500);
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    chk("rh_rel_valid", 32'(fetch_valid), 1);
    chk("rh_rel_addr",  32'(fetch_addr), 32'h500);

    // Reset mid-operation clears request, pc and sticky flag.
    drv(0, 1, KIND_CALL, 19'h00700, 19'h00600, 0);
    step();
    chk("pre_rst_empty", 32'(ras_empty), 0);
    rst = 1'b1;
    drv(0, 0, KIND_JUMP, 0, 0, 0);
    step();
    chk("mrst_valid", 32'(fetch_valid), 0);
    chk("mrst_addr",  32'(fetch_addr), 0);
    chk("mrst_unf",   32'(ras_unf), 0);
    chk("mrst_empty", 32'(ras_empty), 1);
    rst = 1'b0;
    step();
    chk("mrst_boot_valid", 32'(fetch_valid), 1);
    chk("mrst_boot_addr",  32'(fetch_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
